// File: rtl/cpu_core.sv
// cpu_core: 32-bit multi-cycle integer core for the 5-bit-opcode ISA.
// Each instruction runs FETCH -> EXEC (-> MEM for lw) and commits once.
// The register file, instruction ROM and data RAM are external; the core
// keeps only PC, IR and the sequencing state.
module cpu_core (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    output logic        wren,
    output logic [31:0] address_dmem,
    output logic [31:0] data,
    input  logic [31:0] q_dmem
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRA  = 5'b00101;

    // r30 doubles as the overflow/exception status register, r31 is the link register
    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_LINK   = 5'd31;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] ir_reg;

    logic [31:0] instr;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic [31:0] imm_sext;
    logic [31:0] target;
    logic [31:0] pc_plus1;
    logic [31:0] pc_branch;

    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] sum_ab;
    logic [31:0] diff_ab;
    logic [31:0] sum_imm;
    logic        ovf_add;
    logic        ovf_sub;
    logic        ovf_addi;

    logic        wr_req;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    logic [31:0] pc_next;
    logic        unused_low_bits;

    // In EXEC the ROM output is live; in MEM the latched copy keeps rd/rs stable.
    assign instr     = (state_reg == ST_MEM) ? ir_reg : q_imem;
    assign op        = instr[31:27];
    assign rd        = instr[26:22];
    assign rs        = instr[21:17];
    assign rt        = instr[16:12];
    assign shamt     = instr[11:7];
    assign aluop     = instr[6:2];
    assign imm_sext  = {{15{instr[16]}}, instr[16:0]};
    assign target    = {5'd0, instr[26:0]};
    assign pc_plus1  = pc_reg + 32'd1;
    assign pc_branch = pc_plus1 + imm_sext;
    assign unused_low_bits = ^instr[1:0];

    // Register-file read port selection depends on the instruction class.
    always_comb begin
        ctrl_readRegA = rs;
        ctrl_readRegB = rt;
        case (op)
            OP_SW, OP_JR: ctrl_readRegB = rd;
            OP_BNE, OP_BLT: begin
                ctrl_readRegA = rd;
                ctrl_readRegB = rs;
            end
            OP_BEX:  ctrl_readRegA = REG_STATUS;
            default: ;
        endcase
    end

    assign opa = data_readRegA;
    assign opb = data_readRegB;

    // Adders and signed-overflow detection shared by add, sub and addi.
    always_comb begin
        sum_ab   = opa + opb;
        diff_ab  = opa - opb;
        sum_imm  = opa + imm_sext;
        ovf_add  = (opa[31] == opb[31]) && (sum_ab[31] != opa[31]);
        ovf_sub  = (opa[31] != opb[31]) && (diff_ab[31] != opa[31]);
        ovf_addi = (opa[31] == imm_sext[31]) && (sum_imm[31] != opa[31]);
    end

    // Commit decision: which register is written with what, and where the PC goes.
    always_comb begin
        wr_req  = 1'b0;
        wr_idx  = rd;
        wr_data = 32'd0;
        pc_next = pc_plus1;
        if (state_reg == ST_EXEC) begin
            case (op)
                OP_RTYPE: begin
                    case (aluop)
                        ALU_ADD: begin
                            wr_req = 1'b1;
                            if (ovf_add) begin
                                wr_idx  = REG_STATUS;
                                wr_data = 32'd1;
                            end else begin
                                wr_data = sum_ab;
                            end
                        end
                        ALU_SUB: begin
                            wr_req = 1'b1;
                            if (ovf_sub) begin
                                wr_idx  = REG_STATUS;
                                wr_data = 32'd3;
                            end else begin
                                wr_data = diff_ab;
                            end
                        end
                        ALU_AND: begin
                            wr_req  = 1'b1;
                            wr_data = opa & opb;
                        end
                        ALU_OR: begin
                            wr_req  = 1'b1;
                            wr_data = opa | opb;
                        end
                        ALU_SLL: begin
                            wr_req  = 1'b1;
                            wr_data = opa << shamt;
                        end
                        ALU_SRA: begin
                            wr_req  = 1'b1;
                            wr_data = $unsigned($signed(opa) >>> shamt);
                        end
                        default: ;
                    endcase
                end
                OP_ADDI: begin
                    wr_req = 1'b1;
                    if (ovf_addi) begin
                        wr_idx  = REG_STATUS;
                        wr_data = 32'd2;
                    end else begin
                        wr_data = sum_imm;
                    end
                end
                OP_J: pc_next = target;
                OP_JAL: begin
                    wr_req  = 1'b1;
                    wr_idx  = REG_LINK;
                    wr_data = pc_plus1;
                    pc_next = target;
                end
                OP_JR: pc_next = opb;
                OP_BNE: begin
                    if (opa != opb) pc_next = pc_branch;
                end
                OP_BLT: begin
                    if ($signed(opa) < $signed(opb)) pc_next = pc_branch;
                end
                OP_SETX: begin
                    wr_req  = 1'b1;
                    wr_idx  = REG_STATUS;
                    wr_data = target;
                end
                OP_BEX: begin
                    if (opa != 32'd0) pc_next = target;
                end
                default: ;
            endcase
        end else if (state_reg == ST_MEM) begin
            wr_req  = 1'b1;
            wr_idx  = rd;
            wr_data = q_dmem;
        end
    end

    assign address_imem     = pc_reg;
    assign ctrl_writeEnable = reset && wr_req && (wr_idx != 5'd0);
    assign ctrl_writeReg    = wr_idx;
    assign data_writeReg    = wr_data;
    assign wren             = reset && (state_reg == ST_EXEC) && (op == OP_SW);
    assign address_dmem     = sum_imm;
    assign data             = opb;

    // Instruction sequencer: PC advances only when an instruction commits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= ST_FETCH;
            pc_reg    <= 32'd0;
            ir_reg    <= 32'd0;
        end else begin
            case (state_reg)
                ST_FETCH: state_reg <= ST_EXEC;
                ST_EXEC: begin
                    ir_reg <= q_imem;
                    if (op == OP_LW) begin
                        state_reg <= ST_MEM;
                    end else begin
                        pc_reg    <= pc_next;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    pc_reg    <= pc_next;
                    state_reg <= ST_FETCH;
                end
                default: state_reg <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Testbench for cpu_core: single-instruction vector table plus short programs
// for timing, store/load, call/return, exception branch and reset abort.
module tb_cpu_core;

    logic        clock;
    logic        reset;
    logic [31:0] address_imem;
    logic [31:0] q_imem;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;

    int nchecks = 0;
    int nerrors = 0;

    logic [31:0] rom [0:63];
    logic [31:0] ram [0:15];
    logic [31:0] rf  [0:31];
    logic        load_req;
    logic [31:0] pre_r1, pre_r2, pre_r30, pre_m4;
    int          wr_count, sw_count;
    int          cyc_cnt;
    logic [4:0]  wlog_reg  [0:15];
    logic [31:0] wlog_data [0:15];
    int          wlog_cyc  [0:15];
    logic [31:0] sw_addr, sw_data;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] r1, r2, r30;
        int          nwr;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] pc;
        int          cyc;
        int          nsw;
        logic [31:0] saddr, sdata;
    } vec_t;

    vec_t vecs[$];

    cpu_core dut (
        .clock            (clock),
        .reset            (reset),
        .address_imem     (address_imem),
        .q_imem           (q_imem),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .wren             (wren),
        .address_dmem     (address_dmem),
        .data             (data),
        .q_dmem           (q_dmem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign data_readRegA = rf[ctrl_readRegA];
    assign data_readRegB = rf[ctrl_readRegB];

    // Registered ROM/RAM, register file, and a log of every write the core issues.
    always @(posedge clock) begin
        q_imem <= rom[address_imem[5:0]];
        q_dmem <= ram[address_dmem[3:0]];
        if (load_req) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
            rf[1]  <= pre_r1;
            rf[2]  <= pre_r2;
            rf[30] <= pre_r30;
            for (int i = 0; i < 16; i++) ram[i] <= 32'd0;
            ram[4]   <= pre_m4;
            wr_count <= 0;
            sw_count <= 0;
            cyc_cnt  <= 0;
        end else if (reset) begin
            cyc_cnt <= cyc_cnt + 1;
            if (ctrl_writeEnable) begin
                if (ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
                if (wr_count < 16) begin
                    wlog_reg[wr_count]  <= ctrl_writeReg;
                    wlog_data[wr_count] <= data_writeReg;
                    wlog_cyc[wr_count]  <= cyc_cnt;
                end
                wr_count <= wr_count + 1;
            end
            if (wren) begin
                ram[address_dmem[3:0]] <= data;
                sw_count <= sw_count + 1;
                sw_addr  <= address_dmem;
                sw_data  <= data;
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] shamt,
                                          input logic [4:0] aluop);
        return {5'b00000, rd, rs, rt, shamt, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
        return {op, t};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] r30,
                                input int nwr, input logic [4:0] wreg,
                                input logic [31:0] wdata, input logic [31:0] pc,
                                input int cyc, input int nsw,
                                input logic [31:0] saddr, input logic [31:0] sdata);
        vec_t v;
        v.instr = instr; v.r1 = r1; v.r2 = r2; v.r30 = r30;
        v.nwr = nwr; v.wreg = wreg; v.wdata = wdata; v.pc = pc;
        v.cyc = cyc; v.nsw = nsw; v.saddr = saddr; v.sdata = sdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 32'd0;
    endtask

    // Hold reset low for two edges, preload state, check reset outputs, release.
    task automatic prep(input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] r30, input logic [31:0] m4);
        @(negedge clock);
        reset    = 1'b0;
        pre_r1   = r1;
        pre_r2   = r2;
        pre_r30  = r30;
        pre_m4   = m4;
        load_req = 1'b1;
        @(negedge clock);
        load_req = 1'b0;
        @(negedge clock);
        chk("reset address_imem", address_imem, 32'd0);
        chk("reset ctrl_writeEnable", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("reset wren", {31'd0, wren}, 32'd0);
        reset = 1'b1;
    endtask

    task automatic run_until_move(output int cycles);
        cycles = 0;
        do begin
            @(posedge clock);
            #1;
            cycles++;
        end while (address_imem == 32'd0 && cycles < 12);
    endtask

    task automatic run_until_pc(input logic [31:0] pc, output int cycles);
        cycles = 0;
        do begin
            @(posedge clock);
            #1;
            cycles++;
        end while (address_imem != pc && cycles < 20);
    endtask

    initial begin
        int cyc;
        reset    = 1'b0;
        load_req = 1'b0;
        pre_r1 = 0; pre_r2 = 0; pre_r30 = 0; pre_m4 = 0;
        clear_rom();

        //             instr                                 r1            r2    r30  nwr reg data          pc            cyc nsw addr data
        vecs.push_back(mk(enc_i(5'b00101, 1, 0, 17'd5),     0,            0,    0,   1,  1,  32'd5,        1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_r(3, 1, 2, 0, 5'd0),          5,            7,    0,   1,  3,  32'd12,       1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_r(3, 1, 1, 0, 5'd0),          32'h7FFFFFFF, 0,    0,   1,  30, 32'd1,        1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_r(3, 1, 2, 0, 5'd0),          32'hFFFFFFFF, 1,    0,   1,  3,  32'd0,        1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_r(4, 1, 2, 0, 5'd1),          32'h80000000, 1,    0,   1,  30, 32'd3,        1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_r(4, 1, 2, 0, 5'd1),          3,            5,    0,   1,  4,  32'hFFFFFFFE, 1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_r(5, 1, 2, 0, 5'd2),          32'hF0F0,     32'hFF00, 0, 1, 5, 32'hF000,     1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_r(5, 1, 2, 0, 5'd3),          32'hF0F0,     32'hFF00, 0, 1, 5, 32'hFFF0,     1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_r(6, 1, 0, 4, 5'd4),          3,            0,    0,   1,  6,  32'd48,       1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_r(7, 1, 0, 2, 5'd5),          32'hFFFFFFF0, 0,    0,   1,  7,  32'hFFFFFFFC, 1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_i(5'b00101, 8, 1, 17'd1),     32'h7FFFFFFF, 0,    0,   1,  30, 32'd2,        1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_i(5'b00101, 8, 1, 17'h1FFFF), 0,            0,    0,   1,  8,  32'hFFFFFFFF, 1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_r(0, 1, 2, 0, 5'd0),          5,            7,    0,   0,  0,  0,            1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_r(3, 1, 2, 0, 5'd6),          5,            7,    0,   0,  0,  0,            1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_j(5'b00001, 27'd10),          0,            0,    0,   0,  0,  0,            10,           2,  0,  0, 0));
        vecs.push_back(mk(enc_j(5'b00011, 27'd10),          0,            0,    0,   1,  31, 32'd1,        10,           2,  0,  0, 0));
        vecs.push_back(mk(enc_i(5'b00100, 1, 0, 17'd0),     25,           0,    0,   0,  0,  0,            25,           2,  0,  0, 0));
        vecs.push_back(mk(enc_i(5'b00010, 1, 2, 17'd2),     3,            5,    0,   0,  0,  0,            3,            2,  0,  0, 0));
        vecs.push_back(mk(enc_i(5'b00010, 1, 1, 17'd2),     3,            5,    0,   0,  0,  0,            1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_i(5'b00110, 1, 2, 17'd2),     3,            5,    0,   0,  0,  0,            3,            2,  0,  0, 0));
        vecs.push_back(mk(enc_i(5'b00110, 2, 1, 17'd2),     3,            5,    0,   0,  0,  0,            1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_i(5'b00110, 1, 2, 17'd2),     32'hFFFFFFFF, 1,    0,   0,  0,  0,            3,            2,  0,  0, 0));
        vecs.push_back(mk(enc_i(5'b00110, 1, 2, 17'h1FFFD), 3,            5,    0,   0,  0,  0,            32'hFFFFFFFE, 2,  0,  0, 0));
        vecs.push_back(mk(enc_j(5'b10101, 27'd9),           0,            0,    0,   1,  30, 32'd9,        1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_j(5'b10110, 27'd20),          0,            0,    9,   0,  0,  0,            20,           2,  0,  0, 0));
        vecs.push_back(mk(enc_j(5'b10110, 27'd20),          0,            0,    0,   0,  0,  0,            1,            2,  0,  0, 0));
        vecs.push_back(mk(enc_i(5'b00111, 2, 1, 17'd1),     3,            7,    0,   0,  0,  0,            1,            2,  1,  4, 7));
        vecs.push_back(mk(enc_i(5'b01000, 5, 1, 17'd1),     3,            0,    0,   1,  5,  32'h12345678, 1,            3,  0,  0, 0));
        vecs.push_back(mk(enc_i(5'b11111, 3, 1, 17'd5),     3,            0,    0,   0,  0,  0,            1,            2,  0,  0, 0));

        foreach (vecs[i]) begin
            clear_rom();
            rom[0] = vecs[i].instr;
            prep(vecs[i].r1, vecs[i].r2, vecs[i].r30, 32'h12345678);
            run_until_move(cyc);
            $display("vec %0d instr=%h pc=%h cycles=%0d writes=%0d stores=%0d",
                     i, vecs[i].instr, address_imem, cyc, wr_count, sw_count);
            chk($sformatf("v%0d cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            chk($sformatf("v%0d next pc", i), address_imem, vecs[i].pc);
            chk($sformatf("v%0d write count", i), 32'(wr_count), 32'(vecs[i].nwr));
            if (vecs[i].nwr > 0) begin
                chk($sformatf("v%0d write reg", i), {27'd0, wlog_reg[0]}, {27'd0, vecs[i].wreg});
                chk($sformatf("v%0d write data", i), wlog_data[0], vecs[i].wdata);
            end
            chk($sformatf("v%0d store count", i), 32'(sw_count), 32'(vecs[i].nsw));
            if (vecs[i].nsw > 0) begin
                chk($sformatf("v%0d store addr", i), sw_addr, vecs[i].saddr);
                chk($sformatf("v%0d store data", i), sw_data, vecs[i].sdata);
            end
        end

        // Three-instruction program: commit cycles 1, 3, 5 after reset release.
        clear_rom();
        rom[0] = enc_i(5'b00101, 1, 0, 17'd5);
        rom[1] = enc_i(5'b00101, 2, 0, 17'd7);
        rom[2] = enc_r(3, 1, 2, 0, 5'd0);
        prep(0, 0, 0, 0);
        for (int k = 0; k < 20 && wr_count < 3; k++) begin
            @(posedge clock);
            #1;
        end
        $display("seq addi/addi/add: writes=%0d pc=%h", wr_count, address_imem);
        chk("prog write count", 32'(wr_count), 32'd3);
        chk("prog r1 reg", {27'd0, wlog_reg[0]}, 32'd1);
        chk("prog r1 data", wlog_data[0], 32'd5);
        chk("prog r1 cycle", 32'(wlog_cyc[0]), 32'd1);
        chk("prog r2 reg", {27'd0, wlog_reg[1]}, 32'd2);
        chk("prog r2 data", wlog_data[1], 32'd7);
        chk("prog r2 cycle", 32'(wlog_cyc[1]), 32'd3);
        chk("prog r3 reg", {27'd0, wlog_reg[2]}, 32'd3);
        chk("prog r3 data", wlog_data[2], 32'd12);
        chk("prog r3 cycle", 32'(wlog_cyc[2]), 32'd5);

        // sw r2,4(r0) then lw r5,4(r0): one store pulse, load data returns in MEM.
        clear_rom();
        rom[0] = enc_i(5'b00111, 2, 0, 17'd4);
        rom[1] = enc_i(5'b01000, 5, 0, 17'd4);
        prep(0, 7, 0, 0);
        run_until_pc(32'd2, cyc);
        $display("seq sw/lw: stores=%0d addr=%h data=%h writes=%0d cycles=%0d",
                 sw_count, sw_addr, sw_data, wr_count, cyc);
        chk("swlw cycles", 32'(cyc), 32'd5);
        chk("swlw store count", 32'(sw_count), 32'd1);
        chk("swlw store addr", sw_addr, 32'd4);
        chk("swlw store data", sw_data, 32'd7);
        chk("swlw write count", 32'(wr_count), 32'd1);
        chk("swlw load reg", {27'd0, wlog_reg[0]}, 32'd5);
        chk("swlw load data", wlog_data[0], 32'd7);
        chk("swlw load cycle", 32'(wlog_cyc[0]), 32'd4);

        // jal 10 then jr r31 returns to 1.
        clear_rom();
        rom[0]  = enc_j(5'b00011, 27'd10);
        rom[10] = enc_i(5'b00100, 31, 0, 17'd0);
        prep(0, 0, 0, 0);
        run_until_pc(32'd1, cyc);
        $display("seq jal/jr: pc=%h cycles=%0d writes=%0d", address_imem, cyc, wr_count);
        chk("jaljr return pc", address_imem, 32'd1);
        chk("jaljr cycles", 32'(cyc), 32'd4);
        chk("jaljr link reg", {27'd0, wlog_reg[0]}, 32'd31);
        chk("jaljr link data", wlog_data[0], 32'd1);

        // setx 9 then bex 20 is taken.
        clear_rom();
        rom[0] = enc_j(5'b10101, 27'd9);
        rom[1] = enc_j(5'b10110, 27'd20);
        prep(0, 0, 0, 0);
        run_until_pc(32'd20, cyc);
        $display("seq setx/bex: pc=%h cycles=%0d", address_imem, cyc);
        chk("setxbex pc", address_imem, 32'd20);
        chk("setxbex cycles", 32'(cyc), 32'd4);

        // Reset dropped while lw sits in MEM: no write, PC back to 0, then a clean restart.
        clear_rom();
        rom[0] = enc_j(5'b00001, 27'd5);
        rom[5] = enc_i(5'b01000, 5, 0, 17'd4);
        prep(0, 0, 0, 32'hDEAD0001);
        repeat (4) @(posedge clock);
        #1;
        chk("abort pc before reset", address_imem, 32'd5);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort writeEnable", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("abort wren", {31'd0, wren}, 32'd0);
        @(posedge clock);
        #1;
        chk("abort pc after reset", address_imem, 32'd0);
        chk("abort write count", 32'(wr_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 10 && wr_count < 1; k++) begin
            @(posedge clock);
            #1;
        end
        $display("seq reset-abort: restart writes=%0d data=%h", wr_count, wlog_data[0]);
        chk("restart write count", 32'(wr_count), 32'd1);
        chk("restart load data", wlog_data[0], 32'hDEAD0001);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
Name:
cpu_core

Overview:
- 32-bit multi-cycle (non-pipelined) CPU core implementing the team's 5-bit-opcode integer ISA. Mul/div are not supported.
- Drives an external synchronous instruction ROM, data RAM and 32x32 register file. It holds no register storage beyond PC, IR and FSM state.
- Sits at the top of the system wrapper, alongside ROM, RAM and regfile.

Parameters:
- None.

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- address_imem  out  32  instruction address (= PC)
- q_imem  in  32  ROM data, registered one edge after the address
- ctrl_writeEnable  out  1  regfile write strobe
- ctrl_writeReg  out  5  regfile write index
- ctrl_readRegA  out  5  regfile read index A
- ctrl_readRegB  out  5  regfile read index B
- data_writeReg  out  32  regfile write data
- data_readRegA  in  32  regfile read data A (combinational)
- data_readRegB  in  32  regfile read data B (combinational)
- wren  out  1  RAM write enable
- address_dmem  out  32  RAM address (RAM uses [11:0])
- data  out  32  RAM write data
- q_dmem  in  32  RAM data, registered one edge after the address

Behaviour:
- Reset: at a rising edge with reset=0, set PC=0 and state=FETCH. While reset is low, ctrl_writeEnable=0 and wren=0.
- Instruction fields:
  - op=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], shamt=[11:7], aluop=[6:2].
  - imm=[16:0], sign-extended to 32 bits.
  - T=[26:0], zero-extended.
- FSM states: FETCH -> EXEC -> (MEM for lw) -> FETCH.
  - FETCH: address_imem=PC. No writes.
  - EXEC: q_imem is valid and latched into IR. Decode, read regs, compute. Non-lw instructions commit at the end of this cycle, so each takes 2 cycles.
  - MEM (lw only): q_dmem is valid; write it to rd. lw takes 3 cycles.
- address_imem holds PC for the whole instruction. PC updates only at commit.
- R-type (op 00000), A=rs, B=rt; result written to rd:
  - add 00000, sub 00001, and 00010, or 00011.
  - sll 00100: A<<shamt. sra 00101: A>>>shamt, arithmetic.
  - Any other aluop is a no-op.
- addi 00101: rd=rs+imm.
- Overflow: signed overflow writes r30 instead of rd, and rd is left unchanged. r30 gets 1 for add, 2 for addi, 3 for sub.
- sw 00111: A=rs, B=rd, address_dmem=rs+imm, data=B, wren=1 in EXEC only.
- lw 01000: address_dmem=rs+imm driven in EXEC and held in MEM; rd=q_dmem in MEM.
- j 00001: PC=T.
- jal 00011: r31=PC+1, PC=T.
- jr 00100: B=rd, PC=B.
- bne 00010: A=rd, B=rs. If A!=B then PC=PC+1+imm.
- blt 00110: A=rd, B=rs. If A<B (signed) then PC=PC+1+imm.
- setx 10101: r30=T.
- bex 10110: A=r30. If A!=0 then PC=T.
- Unknown opcode: no-op.
- Default next PC is PC+1, 32-bit wrap-around.
- ctrl_writeEnable is asserted only in the commit cycle. Writes to r0 are suppressed (ctrl_writeEnable=0).
- wren is 0 in every state other than sw/EXEC.
- Reset low mid-instruction aborts the instruction: no write is issued and the core returns to FETCH with PC=0.

Test Plan:
- Reset, then ROM "addi r1,r0,5; addi r2,r0,7; add r3,r1,r2" -> r1=5 (cycle 1), r2=7 (cycle 3), r3=12 (cycle 5).
- r1=0x7FFFFFFF; add r3,r1,r1 -> r30=1 and r3 unchanged. Then sub r4,r0-style overflow (0x80000000-1) -> r30=3.
- sw r2,4(r0) then lw r5,4(r0), with r2=7 -> wren pulses once with address 4 and data 7; lw takes 3 cycles and r5=7.
- r1=3, r2=5: blt r1,r2,+2 skips two instructions; bne r1,r1,+2 falls through; beq-style check confirms PC+1+N arithmetic.
- jal 10 -> r31=PC+1 and PC=10; jr r31 returns. setx 9 then bex 20 -> PC=20. With r30=0, bex falls through.
- sll r6,r1,4 with r1=3 -> 48; sra of 0xFFFFFFF0 by 2 -> 0xFFFFFFFC. Assert reset low mid-lw -> no write; PC=0.
